// File: rtl/fe_event_decoder_pkg.sv
// fe_event_decoder_pkg: front-end FIFO entry layout, command/event encodings and entry decode helper
package fe_event_decoder_pkg;

    typedef enum logic [1:0] {
        CMD_DATA = 2'd0,
        CMD_TIME = 2'd1,
        CMD_STAT = 2'd2,
        CMD_RSVD = 2'd3
    } fe_cmd_e;

    typedef enum logic [1:0] {
        EVT_DATA = 2'd0,
        EVT_TIME = 2'd1,
        EVT_STAT = 2'd2
    } evt_type_e;

    localparam int ENTRY_W     = 18;
    localparam int CMD_LSB     = 0;
    localparam int CMD_LEN     = 2;
    localparam int SDELTA_LSB  = 2;
    localparam int SDELTA_LEN  = 3;
    localparam int DATA_LSB    = 5;
    localparam int DATA_LEN    = 8;
    localparam int STATUS_LSB  = 13;
    localparam int STATUS_LEN  = 5;
    localparam int TDELTA_LSB  = 2;
    localparam int TDELTA_LEN  = 16;

    typedef struct packed {
        fe_cmd_e                 cmd;
        logic [TDELTA_LEN-1:0]   delta;
        logic [DATA_LEN-1:0]     data;
        logic [STATUS_LEN-1:0]   status;
    } fe_entry_t;

    // Reserved entries decode with zero delta so they never move the time base
    function automatic fe_entry_t decode_entry(input logic [ENTRY_W-1:0] e);
        fe_entry_t r;
        r.cmd    = fe_cmd_e'(e[CMD_LSB +: CMD_LEN]);
        r.delta  = (r.cmd == CMD_TIME) ? e[TDELTA_LSB +: TDELTA_LEN] :
                   (r.cmd == CMD_RSVD) ? '0 : TDELTA_LEN'(e[SDELTA_LSB +: SDELTA_LEN]);
        r.data   = (r.cmd == CMD_DATA) ? e[DATA_LSB +: DATA_LEN] : '0;
        r.status = (r.cmd == CMD_TIME) ? '0 : e[STATUS_LSB +: STATUS_LEN];
        return r;
    endfunction

    function automatic evt_type_e to_evt_type(input fe_cmd_e cmd);
        return (cmd == CMD_TIME) ? EVT_TIME : (cmd == CMD_STAT) ? EVT_STAT : EVT_DATA;
    endfunction

endpackage

// File: rtl/fe_event_decoder.sv
// fe_event_decoder: pops front-end FIFO entries, rebuilds absolute time and emits event records
module fe_event_decoder
    import fe_event_decoder_pkg::*;
#(
    parameter int pABS_TIME_WIDTH = 32,
    parameter int pCOUNT_WIDTH    = 24
) (
    input  logic                       cwusb_clk,
    input  logic                       reset_n,
    input  logic                       I_enable,
    input  logic                       I_clear,
    input  logic                       I_emit_time,
    input  logic [ENTRY_W-1:0]         I_fifo_dout,
    input  logic                       I_fifo_empty,
    output logic                       O_fifo_rd,
    output logic                       O_evt_valid,
    input  logic                       I_evt_ready,
    output logic [1:0]                 O_evt_type,
    output logic [DATA_LEN-1:0]        O_evt_data,
    output logic [STATUS_LEN-1:0]      O_evt_status,
    output logic [pABS_TIME_WIDTH-1:0] O_evt_time,
    output logic [pCOUNT_WIDTH-1:0]    O_evt_count,
    output logic                       O_decode_error,
    output logic [pCOUNT_WIDTH-1:0]    O_err_count
);

    logic [pABS_TIME_WIDTH-1:0] abs_time_q, abs_time_d;
    logic                       evt_valid_q, evt_valid_d;
    evt_type_e                  evt_type_q, evt_type_d;
    logic [DATA_LEN-1:0]        evt_data_q, evt_data_d;
    logic [STATUS_LEN-1:0]      evt_status_q, evt_status_d;
    logic [pABS_TIME_WIDTH-1:0] evt_time_q, evt_time_d;
    logic [pCOUNT_WIDTH-1:0]    evt_count_q, evt_count_d;
    logic                       decode_error_q, decode_error_d;
    logic [pCOUNT_WIDTH-1:0]    err_count_q, err_count_d;

    fe_entry_t                  ent;
    logic                       pop, rsvd, emit;
    logic [pABS_TIME_WIDTH-1:0] time_next;

    // Reset gates the pop so an asserted reset never consumes a FIFO entry
    always_comb begin
        ent       = decode_entry(I_fifo_dout);
        pop       = reset_n & I_enable & ~I_fifo_empty & ~I_clear & (~evt_valid_q | I_evt_ready);
        rsvd      = ent.cmd == CMD_RSVD;
        emit      = pop & ~rsvd & ((ent.cmd != CMD_TIME) | I_emit_time);
        time_next = abs_time_q + pABS_TIME_WIDTH'(ent.delta);
        abs_time_d     = abs_time_q;
        evt_valid_d    = evt_valid_q;
        evt_type_d     = evt_type_q;
        evt_data_d     = evt_data_q;
        evt_status_d   = evt_status_q;
        evt_time_d     = evt_time_q;
        evt_count_d    = evt_count_q;
        decode_error_d = decode_error_q;
        err_count_d    = err_count_q;
        if (I_clear) begin
            abs_time_d     = '0;
            evt_valid_d    = 1'b0;
            evt_type_d     = EVT_DATA;
            evt_data_d     = '0;
            evt_status_d   = '0;
            evt_time_d     = '0;
            evt_count_d    = '0;
            decode_error_d = 1'b0;
            err_count_d    = '0;
        end else begin
            abs_time_d  = (pop & ~rsvd) ? time_next : abs_time_q;
            evt_valid_d = pop ? emit : evt_valid_q & ~I_evt_ready;
            if (emit) begin
                evt_type_d   = to_evt_type(ent.cmd);
                evt_data_d   = ent.data;
                evt_status_d = ent.status;
                evt_time_d   = time_next;
                evt_count_d  = (&evt_count_q) ? evt_count_q : evt_count_q + pCOUNT_WIDTH'(1);
            end
            if (pop & rsvd) begin
                decode_error_d = 1'b1;
                err_count_d    = (&err_count_q) ? err_count_q : err_count_q + pCOUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            abs_time_q     <= '0;
            evt_valid_q    <= 1'b0;
            evt_type_q     <= EVT_DATA;
            evt_data_q     <= '0;
            evt_status_q   <= '0;
            evt_time_q     <= '0;
            evt_count_q    <= '0;
            decode_error_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            abs_time_q     <= abs_time_d;
            evt_valid_q    <= evt_valid_d;
            evt_type_q     <= evt_type_d;
            evt_data_q     <= evt_data_d;
            evt_status_q   <= evt_status_d;
            evt_time_q     <= evt_time_d;
            evt_count_q    <= evt_count_d;
            decode_error_q <= decode_error_d;
            err_count_q    <= err_count_d;
        end
    end

    assign O_fifo_rd      = pop;
    assign O_evt_valid    = evt_valid_q;
    assign O_evt_type     = evt_type_q;
    assign O_evt_data     = evt_data_q;
    assign O_evt_status   = evt_status_q;
    assign O_evt_time     = evt_time_q;
    assign O_evt_count    = evt_count_q;
    assign O_decode_error = decode_error_q;
    assign O_err_count    = err_count_q;

endmodule
